aesl_deadlock_persist_monitor: RTL and testbench

//  Parametrised per-region deadlock monitor for cosim dataflow regions; successor to the fixed-width idx-N monitors.

---
 rtl/aesl_deadlock_pkg.sv | 20 ++
 rtl/aesl_deadlock_prio_enc.sv | 23 ++
 rtl/aesl_deadlock_persist_monitor.sv | 136 +++++++++++++
 tb/tb_aesl_deadlock_persist_monitor.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/aesl_deadlock_pkg.sv
// Shared types and helpers for the dataflow-region deadlock monitors.
package aesl_deadlock_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SUSPECT  = 2'd1,
        DEADLOCK = 2'd2
    } dl_state_e;

    // Elaboration-time ceil(log2(value)); 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            r = ((32'sd1 <<< i) < value) ? (i + 1) : r;
        end
        return r;
    endfunction

endpackage

// File: rtl/aesl_deadlock_prio_enc.sv
// Lowest-set-bit priority encoder with a valid flag; purely combinational.
module aesl_deadlock_prio_enc
    import aesl_deadlock_pkg::*;
#(
    parameter  int N = 16,
    localparam int W = (N > 1) ? clog2(N) : 1
) (
    input  logic [N-1:0] req_i,
    output logic [W-1:0] idx_o,
    output logic         valid_o
);

    // Scan from the top so the lowest requesting index is written last and wins.
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            idx_o   = req_i[i] ? W'(i) : idx_o;
            valid_o = valid_o | req_i[i];
        end
    end

endmodule

// File: rtl/aesl_deadlock_persist_monitor.sv
// Per-region deadlock monitor: raw block condition must persist PERSIST cycles
// before deadlock is flagged; culprit and event count are latched on entry.
module aesl_deadlock_persist_monitor
    import aesl_deadlock_pkg::*;
#(
    parameter int                         N_PROC   = 16,
    parameter int                         N_AXIS   = 12,
    parameter int                         N_IDLE   = 21,
    parameter logic [N_PROC*N_AXIS-1:0]   AXIS_MAP = {(N_PROC*N_AXIS){1'b1}},
    parameter int                         PERSIST  = 64,
    parameter int                         EVT_W    = 8,
    localparam int                        IDX_W    = (N_PROC > 1) ? clog2(N_PROC) : 1,
    localparam int                        CNT_W    = clog2(PERSIST + 1)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [N_AXIS-1:0] axis_block_sigs,
    input  logic [N_IDLE-1:0] inst_idle_sigs,
    input  logic [N_PROC-1:0] inst_block_sigs,
    input  logic              sub_block,
    input  logic              clear,
    output logic              block,
    output logic              deadlock,
    output logic [IDX_W-1:0]  culprit_idx,
    output logic [CNT_W-1:0]  persist_cnt,
    output logic [EVT_W-1:0]  evt_cnt
);

    localparam logic [CNT_W-1:0] PERSIST_C  = CNT_W'(PERSIST);
    localparam logic [CNT_W-1:0] PERSIST_M1 = CNT_W'(PERSIST - 1);

    dl_state_e          state_q, state_d;
    logic               block_q, deadlock_q, deadlock_d;
    logic [IDX_W-1:0]   culprit_q, culprit_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [EVT_W-1:0]   evt_q, evt_d;
    logic [N_PROC-1:0]  cand_s;
    logic               raw_s, enter_s, enc_valid_s;
    logic [IDX_W-1:0]   enc_idx_s;

    // A process is a candidate when it is blocked on a channel it owns.
    always_comb begin
        cand_s = '0;
        for (int p = 0; p < N_PROC; p++) begin
            cand_s[p] = inst_block_sigs[p] & (|(axis_block_sigs & AXIS_MAP[p*N_AXIS +: N_AXIS]));
        end
    end

    assign raw_s = ((|cand_s) | sub_block) & ~(&inst_idle_sigs);

    aesl_deadlock_prio_enc #(.N(N_PROC)) u_prio_enc (
        .req_i   (cand_s),
        .idx_o   (enc_idx_s),
        .valid_o (enc_valid_s)
    );

    // Next-state logic; clear overrides every transition.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        enter_s = 1'b0;
        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (raw_s && (PERSIST == 1)) begin
                        state_d = DEADLOCK;
                        cnt_d   = PERSIST_C;
                        enter_s = 1'b1;
                    end else if (raw_s) begin
                        state_d = SUSPECT;
                        cnt_d   = CNT_W'(1);
                    end else begin
                        cnt_d   = '0;
                    end
                end
                SUSPECT: begin
                    if (!raw_s) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_q == PERSIST_M1) begin
                        state_d = DEADLOCK;
                        cnt_d   = PERSIST_C;
                        enter_s = 1'b1;
                    end else begin
                        cnt_d   = cnt_q + CNT_W'(1);
                    end
                end
                DEADLOCK: begin
                    cnt_d = PERSIST_C;
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
        // enc_valid_s is low only when sub_block alone caused raw; the encoder then yields 0.
        if (enter_s) begin
            culprit_d = enc_valid_s ? enc_idx_s : '0;
            evt_d     = (&evt_q) ? evt_q : (evt_q + EVT_W'(1));
        end else begin
            culprit_d = culprit_q;
            evt_d     = evt_q;
        end
        deadlock_d = (state_d == DEADLOCK);
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            block_q    <= 1'b0;
            deadlock_q <= 1'b0;
            culprit_q  <= '0;
            cnt_q      <= '0;
            evt_q      <= '0;
        end else begin
            state_q    <= state_d;
            block_q    <= raw_s;
            deadlock_q <= deadlock_d;
            culprit_q  <= culprit_d;
            cnt_q      <= cnt_d;
            evt_q      <= evt_d;
        end
    end

    assign block       = block_q;
    assign deadlock    = deadlock_q;
    assign culprit_idx = culprit_q;
    assign persist_cnt = cnt_q;
    assign evt_cnt     = evt_q;

endmodule

// File: tb/tb_aesl_deadlock_persist_monitor.sv
// Directed bench: three monitor instances (PERSIST=4, PERSIST=1, PERSIST=2/EVT_W=2) on shared inputs.
module tb_aesl_deadlock_persist_monitor;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] axis  = '0;
    logic [2:0] idle  = '0;
    logic [7:0] iblk  = '0;
    logic       sub   = 1'b0;
    logic       clr   = 1'b0;

    logic       a_block, a_dl, b_block, b_dl, c_block, c_dl;
    logic [2:0] a_cul, b_cul, c_cul;
    logic [2:0] a_cnt;
    logic [0:0] b_cnt;
    logic [1:0] c_cnt;
    logic [7:0] a_evt, b_evt;
    logic [1:0] c_evt;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    // Process p owns channel p%4.
    aesl_deadlock_persist_monitor #(.N_PROC(8), .N_AXIS(4), .N_IDLE(3), .AXIS_MAP(32'h8421_8421),
        .PERSIST(4), .EVT_W(8)) u_a (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(iblk), .sub_block(sub), .clear(clr), .block(a_block), .deadlock(a_dl),
        .culprit_idx(a_cul), .persist_cnt(a_cnt), .evt_cnt(a_evt));

    aesl_deadlock_persist_monitor #(.N_PROC(8), .N_AXIS(4), .N_IDLE(3), .AXIS_MAP(32'h8421_8421),
        .PERSIST(1), .EVT_W(8)) u_b (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(iblk), .sub_block(sub), .clear(clr), .block(b_block), .deadlock(b_dl),
        .culprit_idx(b_cul), .persist_cnt(b_cnt), .evt_cnt(b_evt));

    aesl_deadlock_persist_monitor #(.N_PROC(8), .N_AXIS(4), .N_IDLE(3), .AXIS_MAP(32'h8421_8421),
        .PERSIST(2), .EVT_W(2)) u_c (
        .clock(clock), .reset(reset), .axis_block_sigs(axis), .inst_idle_sigs(idle),
        .inst_block_sigs(iblk), .sub_block(sub), .clear(clr), .block(c_block), .deadlock(c_dl),
        .culprit_idx(c_cul), .persist_cnt(c_cnt), .evt_cnt(c_evt));

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic apply_reset();
        @(negedge clock);
        axis = '0; idle = '0; iblk = '0; sub = 1'b0; clr = 1'b0;
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        tests++; if (a_block !== 1'b0) begin fails++; $display("FAIL reset_block got %0d exp 0", a_block); end
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL reset_deadlock got %0d exp 0", a_dl); end
        tests++; if (a_cul !== 3'd0) begin fails++; $display("FAIL reset_culprit got %0d exp 0", a_cul); end
        tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL reset_cnt got %0d exp 0", a_cnt); end
        tests++; if (a_evt !== 8'd0) begin fails++; $display("FAIL reset_evt got %0d exp 0", a_evt); end
        tests++; if (c_evt !== 2'd0) begin fails++; $display("FAIL reset_c_evt got %0d exp 0", c_evt); end
    endtask

    task automatic test_basic_detect();
        apply_reset();
        iblk = 8'h08; axis = 4'h8;            // cand[3]
        tick(1);
        tests++; if (a_block !== 1'b1) begin fails++; $display("FAIL t1_block got %0d exp 1", a_block); end
        tests++; if (a_cnt !== 3'd1) begin fails++; $display("FAIL t1_cnt1 got %0d exp 1", a_cnt); end
        tick(2);
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL t1_early_dl got %0d exp 0", a_dl); end
        tests++; if (a_cnt !== 3'd3) begin fails++; $display("FAIL t1_cnt3 got %0d exp 3", a_cnt); end
        tick(1);
        tests++; if (a_dl !== 1'b1) begin fails++; $display("FAIL t1_deadlock got %0d exp 1", a_dl); end
        tests++; if (a_cul !== 3'd3) begin fails++; $display("FAIL t1_culprit got %0d exp 3", a_cul); end
        tests++; if (a_evt !== 8'd1) begin fails++; $display("FAIL t1_evt got %0d exp 1", a_evt); end
        tests++; if (a_cnt !== 3'd4) begin fails++; $display("FAIL t1_cnt4 got %0d exp 4", a_cnt); end
        iblk = '0; axis = '0;
        tick(2);
        tests++; if (a_block !== 1'b0) begin fails++; $display("FAIL t1_block_drop got %0d exp 0", a_block); end
        tests++; if (a_cnt !== 3'd4) begin fails++; $display("FAIL t1_cnt_sat got %0d exp 4", a_cnt); end
        tests++; if (a_dl !== 1'b1) begin fails++; $display("FAIL t1_sticky got %0d exp 1", a_dl); end
    endtask

    task automatic test_axis_map();
        apply_reset();
        iblk = 8'h08; axis = 4'h1;            // p3 blocked on channel 0, which it does not own
        tick(3);
        tests++; if (a_block !== 1'b0) begin fails++; $display("FAIL map_block got %0d exp 0", a_block); end
        tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL map_cnt got %0d exp 0", a_cnt); end
    endtask

    task automatic test_gap();
        apply_reset();
        iblk = 8'h01; axis = 4'h1;
        tick(3);
        tests++; if (a_cnt !== 3'd3) begin fails++; $display("FAIL t2_cnt_run1 got %0d exp 3", a_cnt); end
        iblk = '0;
        tick(1);
        tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL t2_cnt_gap got %0d exp 0", a_cnt); end
        iblk = 8'h01;
        tick(3);
        tests++; if (a_cnt !== 3'd3) begin fails++; $display("FAIL t2_cnt_run2 got %0d exp 3", a_cnt); end
        iblk = '0;
        tick(2);
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL t2_deadlock got %0d exp 0", a_dl); end
        tests++; if (a_evt !== 8'd0) begin fails++; $display("FAIL t2_evt got %0d exp 0", a_evt); end
    endtask

    task automatic test_culprit_priority();
        apply_reset();
        iblk = 8'h24; axis = 4'h6;            // cand[5] via ch1, cand[2] via ch2
        tick(4);
        tests++; if (a_dl !== 1'b1) begin fails++; $display("FAIL t3_deadlock got %0d exp 1", a_dl); end
        tests++; if (a_cul !== 3'd2) begin fails++; $display("FAIL t3_culprit got %0d exp 2", a_cul); end
        iblk = '0; axis = '0;
        tick(5);
        tests++; if (a_dl !== 1'b1) begin fails++; $display("FAIL t3_hold got %0d exp 1", a_dl); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL t3_clear_dl got %0d exp 0", a_dl); end
        tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL t3_clear_cnt got %0d exp 0", a_cnt); end
        tests++; if (a_cul !== 3'd2) begin fails++; $display("FAIL t3_culprit_hold got %0d exp 2", a_cul); end
        tests++; if (a_evt !== 8'd1) begin fails++; $display("FAIL t3_evt_hold got %0d exp 1", a_evt); end
    endtask

    task automatic test_all_idle();
        int bad;
        bad = 0;
        apply_reset();
        idle = 3'b111; iblk = 8'h01; axis = 4'h1;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            bad = (a_block !== 1'b0) ? bad + 1 : bad;
        end
        tests++; if (bad != 0) begin fails++; $display("FAIL t4_block got %0d high cycles exp 0", bad); end
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL t4_deadlock got %0d exp 0", a_dl); end
        tests++; if (b_dl !== 1'b0) begin fails++; $display("FAIL t4_b_deadlock got %0d exp 0", b_dl); end
        idle = 3'b011;
        tick(1);
        tests++; if (a_block !== 1'b1) begin fails++; $display("FAIL t4_partial_idle got %0d exp 1", a_block); end
    endtask

    task automatic test_persist_one();
        apply_reset();
        sub = 1'b1;
        tick(1);
        sub = 1'b0;
        tests++; if (b_dl !== 1'b1) begin fails++; $display("FAIL t5_deadlock got %0d exp 1", b_dl); end
        tests++; if (b_cul !== 3'd0) begin fails++; $display("FAIL t5_culprit got %0d exp 0", b_cul); end
        tests++; if (b_cnt !== 1'd1) begin fails++; $display("FAIL t5_cnt got %0d exp 1", b_cnt); end
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL t5_a_no_dl got %0d exp 0", a_dl); end
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        tests++; if (b_dl !== 1'b0) begin fails++; $display("FAIL t5_clear got %0d exp 0", b_dl); end
        tests++; if (b_evt !== 8'd1) begin fails++; $display("FAIL t5_evt got %0d exp 1", b_evt); end
        clr = 1'b1; sub = 1'b1;               // clear wins over simultaneous raw
        tick(1);
        clr = 1'b0;
        tests++; if (b_dl !== 1'b0) begin fails++; $display("FAIL t5_clear_raw got %0d exp 0", b_dl); end
        tick(1);
        sub = 1'b0;
        tests++; if (b_dl !== 1'b1) begin fails++; $display("FAIL t5_redetect got %0d exp 1", b_dl); end
        tests++; if (b_evt !== 8'd2) begin fails++; $display("FAIL t5_evt2 got %0d exp 2", b_evt); end
    endtask

    task automatic test_reset_mid_suspect();
        apply_reset();
        iblk = 8'h08; axis = 4'h8;
        tick(2);
        tests++; if (a_cnt !== 3'd2) begin fails++; $display("FAIL t6_cnt_pre got %0d exp 2", a_cnt); end
        reset = 1'b0;
        #1;
        tests++; if (a_cnt !== 3'd0) begin fails++; $display("FAIL t6_async_cnt got %0d exp 0", a_cnt); end
        tests++; if (a_block !== 1'b0) begin fails++; $display("FAIL t6_async_block got %0d exp 0", a_block); end
        tests++; if (b_dl !== 1'b0) begin fails++; $display("FAIL t6_async_b_dl got %0d exp 0", b_dl); end
        tests++; if (b_evt !== 8'd0) begin fails++; $display("FAIL t6_async_b_evt got %0d exp 0", b_evt); end
        @(negedge clock);
        reset = 1'b1;
        tick(3);
        tests++; if (a_dl !== 1'b0) begin fails++; $display("FAIL t6_no_credit got %0d exp 0", a_dl); end
        tests++; if (a_cnt !== 3'd3) begin fails++; $display("FAIL t6_cnt_post got %0d exp 3", a_cnt); end
        tick(1);
        tests++; if (a_dl !== 1'b1) begin fails++; $display("FAIL t6_full_run got %0d exp 1", a_dl); end
    endtask

    task automatic test_evt_saturate();
        logic [1:0] exp_evt;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            iblk = 8'h01; axis = 4'h1;
            tick(2);
            exp_evt = (i < 3) ? 2'(i + 1) : 2'd3;
            tests++; if (c_dl !== 1'b1) begin fails++; $display("FAIL t7_dl[%0d] got %0d exp 1", i, c_dl); end
            tests++; if (c_evt !== exp_evt) begin fails++; $display("FAIL t7_evt[%0d] got %0d exp %0d", i, c_evt, exp_evt); end
            iblk = '0; clr = 1'b1;
            tick(1);
            clr = 1'b0;
            tests++; if (c_dl !== 1'b0) begin fails++; $display("FAIL t7_clear[%0d] got %0d exp 0", i, c_dl); end
        end
    endtask

    initial begin
        test_reset();
        test_basic_detect();
        test_axis_map();
        test_gap();
        test_culprit_priority();
        test_all_idle();
        test_persist_one();
        test_reset_mid_suspect();
        test_evt_saturate();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
